// File: rtl/mux8_rr_sched_pkg.sv
// Shared definitions for the 8-input round-robin mux scheduler.
package mux8_rr_sched_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  function automatic logic [N_IN-1:0] onehot_of(input logic [SEL_W-1:0] idx);
    onehot_of = N_IN'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Round-robin pick: rotate requests so last+1 sits at bit 0, fixed-priority
// encode the lowest set bit, then un-rotate back to a real index.
module rr_pick8
  import mux8_rr_sched_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0]  base_s;
  logic [2*N_IN-1:0] dbl_s;
  logic [N_IN-1:0]   rot_s;
  logic [SEL_W-1:0]  enc_s;

  // rotate / encode / un-rotate
  always_comb begin
    base_s = last + 3'd1;
    dbl_s  = {req, req} >> base_s;
    rot_s  = dbl_s[N_IN-1:0];
    found  = |rot_s;
    enc_s  = '0;
    for (int i = N_IN-1; i >= 0; i--) begin
      if (rot_s[i]) begin
        enc_s = SEL_W'(i);
      end else begin
        enc_s = enc_s;
      end
    end
    idx = enc_s + base_s;
  end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner scheduler for an 8:1 mux: registered one-hot grant and
// select, starvation-bounded holds, and a one-cycle guard gap between owners.
module mux8_rr_sched
  import mux8_rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_IN-1:0]  req,
  output logic [N_IN-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic             arb_go_s;
  logic             others_s;
  logic             release_s;

  rr_pick8 u_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  assign arb_go_s  = en & pick_found_s;
  assign others_s  = |(req & ~onehot_of(sel_q));
  assign release_s = ~req[sel_q] | ~en | ((hold_cnt_q == HOLD_LAST) & others_s);

  // next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE, ST_GUARD: begin
        if (arb_go_s) begin
          state_d     = ST_GRANT;
          gnt_d       = onehot_of(pick_idx_s);
          sel_d       = pick_idx_s;
          sel_valid_d = 1'b1;
          last_d      = pick_idx_s;
          hold_cnt_d  = '0;
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          sel_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_d     = ST_GUARD;
          gnt_d       = '0;
          sel_valid_d = 1'b0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end else begin
          hold_cnt_d  = hold_cnt_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // state and output registers; pointer resets to 7 so index 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      last_q      <= 3'd7;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench: an owner/age/pointer reference model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_mux8_rr_sched;

  localparam int MAX_HOLD = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       sel_valid;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_owner = -1;
  int m_age   = 0;
  int m_last  = 7;
  int m_sel   = 0;

  mux8_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  always #5 clk = ~clk;

  // reference model: one prediction per rising edge
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] mask;
    logic       rel;
    logic       got;
    exp_t       e;
    if (!rst_n) begin
      m_owner = -1;
      m_age   = 0;
      m_last  = 7;
      m_sel   = 0;
      if (clk) begin
        exp_q.delete();
        exp_q.push_back('{gnt: 8'h00, sel: 3'd0, vld: 1'b0});
      end
    end else begin
      if (m_owner >= 0) begin
        mask = 8'h01 << m_owner;
        rel  = !req[m_owner] || !en || (m_age == MAX_HOLD-1 && (req & ~mask) != 8'h00);
        if (rel) m_owner = -1;
        else if (m_age < MAX_HOLD-1) m_age = m_age + 1;
      end else if (en && req != 8'h00) begin
        got = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          if (!got && req[(m_last + k) % 8]) begin
            got     = 1'b1;
            m_owner = (m_last + k) % 8;
          end
        end
        m_last = m_owner;
        m_sel  = m_owner;
        m_age  = 0;
      end
      e.gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      e.sel = 3'(m_sel);
      e.vld = (m_owner >= 0);
      exp_q.push_back(e);
    end
  end

  // monitor: compare DUT against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({gnt, sel, sel_valid} !== e) begin
        n_bad++;
        $display("FAIL sb t=%0t: got gnt=%h sel=%0d vld=%b, want gnt=%h sel=%0d vld=%b",
                 $time, gnt, sel, sel_valid, e.gnt, e.sel, e.vld);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    en    = 1'b1;

    // single requester, then drop
    req = 8'h01; cyc(4);
    req = 8'h00; cyc(4);

    // all requesting: full rotation with hold limit
    req = 8'hFF; cyc(9 * (MAX_HOLD + 1) + 4);
    req = 8'h00; cyc(4);

    // make 2 the last owner, then contend 2 vs 5
    req = 8'h04; cyc(3);
    req = 8'h00; cyc(3);
    req = 8'h24; cyc(4 * (MAX_HOLD + 1) + 4);
    req = 8'h00; cyc(3);

    // lone requester held long: no forced gap
    req = 8'h08; cyc(100);
    req = 8'h00; cyc(3);

    // enable dropped mid-grant and while others request
    req = 8'h10; cyc(5);
    en  = 1'b0;  cyc(4);
    req = 8'h11; cyc(4);
    en  = 1'b1;  cyc(6);
    req = 8'h00; cyc(3);

    // async reset mid-grant, then 0 must win over 7
    req = 8'h40; cyc(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, sel, sel_valid} !== 12'h000) begin
      n_bad++;
      $display("FAIL async_rst: got gnt=%h sel=%0d vld=%b, want all zero", gnt, sel, sel_valid);
    end
    @(negedge clk);
    req = 8'h81;
    cyc(1);
    rst_n = 1'b1;
    cyc(6);
    req = 8'h00; cyc(3);

    // randomized traffic with sparse changes so holds and limits occur
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 7)] = 1'b0;
      if ($urandom_range(0, 47) == 0) en = ~en;
    end
    en  = 1'b1;
    req = 8'h00;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
